if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch stage feeding the decode stage. Holds the PC and fetches each 32-bit instruction as four byte reads through the shared byte-wide memory port, which the memory arbiter grants per cycle. Presents `{pc, inst}` to the IF/ID boundary with a valid/ready handshake, and redirects on the branch/jump target that decode resolves.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk  in  1  clock; all state updates on the rising edge`
- `rst  in  1  reset, synchronous, active-high`
- `rdy  in  1  global enable; when 0 all state is frozen and mem_req_o=0`
- `branch_enable_i  in  1  redirect request from decode, valid for one cycle`
- `branch_addr_i  in  32  redirect target`
- `id_ready_i  in  1  decode accepts the presented instruction this cycle`
- `mem_grant_i  in  1  arbiter grants the port to fetch this cycle`
- `mem_din_i  in  8  read byte, valid the cycle after a granted request`
- `mem_req_o  out  1  fetch requests the port`
- `mem_a_o  out  32  byte address of the request`
- `pc_o  out  32  PC of the presented instruction`
- `inst_o  out  32  presented instruction`
- `inst_valid_o  out  1  pc_o/inst_o valid`

## Operation
- States: `FETCH` (byte index k=0..3 issued), `DRAIN` (last byte in flight), `HOLD` (instruction presented).
- `FETCH`: mem_req_o=1, mem_a_o=fetch_pc+k. A cycle with mem_grant_i=1 is a granted issue: k increments; on k=3 go to `DRAIN`. Without a grant, address and k hold.
- A `pending` flag is set in every cycle that follows a granted issue. When it is set, mem_din_i is written into byte slot (k_issued) of the assembly register.
- Byte order is little-endian: inst = {b3,b2,b1,b0}.
- `DRAIN`: mem_req_o=0. Capture b3, load inst_o, pc_o=fetch_pc, inst_valid_o=1, go to `HOLD`.
- `HOLD`: mem_req_o=0. Outputs are stable until the cycle where inst_valid_o && id_ready_i. After that edge: inst_valid_o=0, fetch_pc += 4, k=0, `FETCH`.
- Redirect: branch_enable_i=1 (rdy=1) in any state overrides all other transitions:
  - fetch_pc=branch_addr_i, k=0, pending=0, inst_valid_o=0, `FETCH`.
  - Any byte returning the next cycle is discarded.
  - Simultaneous accept and redirect: the redirect wins; there is no +4.
- Target alignment is not checked; addresses are used verbatim. fetch_pc+k and +4 wrap modulo 2^32.
- rdy=0: no state changes, mem_req_o=0. A byte in flight when rdy falls is lost. On rdy=1 the fetch restarts from k=0 at the same fetch_pc.

## Timing
- Reset values (synchronous, next edge): pc_o=0, inst_o=0, inst_valid_o=0, mem_req_o=0, mem_a_o=0, fetch_pc=RESET_PC, k=0, pending=0, state=`FETCH`.
- The first request is issued in the cycle after rst deasserts.
- Best-case latency, with grants every cycle:
  - Bytes issued in cycles 0–3.
  - b3 captured at the end of cycle 4.
  - inst_valid_o=1 from cycle 5.
- Throughput: 6 cycles per instruction, including the accept cycle.
- Each denied grant adds exactly one cycle.
- Redirect asserted in cycle n: the first request to the target is issued in cycle n+1.
- mem_req_o and mem_a_o are combinational from state only, never from mem_grant_i.

## Structure
- Shared defines file: state encodings, `RESET_PC` default, `InstAddrBus`/`InstBus` widths, `True_v`/`False_v`.
- Single module. No sub-module; the byte assembler is only four enabled byte registers.

## Test plan
- Reset, then steady fetch. Memory holds 0x00A00093 at 0x0, grants always, id_ready_i=1.
  - Required: mem_a_o = 0,1,2,3 in cycles 0–3.
  - Required: inst_valid_o=1 in cycle 5 with inst_o=0x00A00093, pc_o=0.
  - Required: the next fetch starts at 0x4.
- Grant stalls: mem_grant_i=0 in the cycle byte 1 is requested.
  - Required: mem_a_o holds 0x1 for two cycles.
  - Required: valid appears in cycle 6 with the correct word.
- Backpressure: id_ready_i=0 for 3 cycles.
  - Required: pc_o, inst_o and inst_valid_o are stable and mem_req_o=0.
  - Required: after accept, the next fetch is at pc+4.
- Mid-fetch redirect: branch_enable_i=1, branch_addr_i=0x100 while k=2.
  - Required: the next request is at 0x100.
  - Required: the stale byte is discarded; inst_o equals the word at 0x100.
- Redirect coincident with accept in `HOLD`, target 0x40.
  - Required: the next pc_o is 0x40, not pc+4.
- Reset mid-fetch, and rdy low mid-fetch.
  - Reset: all outputs return to their reset values on the next edge.
  - rdy low for 2 cycles: no requests are made, and the fetch resumes from k=0 at the same PC.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, the reset PC
// default, truth constants and the fetch FSM state encoding.
package if_fetch_unit_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  localparam logic [InstAddrBus-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic True_v  = 1'b1;
  localparam logic False_v = 1'b0;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch: assembles each 32-bit word from four byte reads on the
// shared memory port and presents {pc, inst} to decode with valid/ready.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   branch_enable_i,
  input  logic [InstAddrBus-1:0] branch_addr_i,
  input  logic                   id_ready_i,
  input  logic                   mem_grant_i,
  input  logic [7:0]             mem_din_i,
  output logic                   mem_req_o,
  output logic [InstAddrBus-1:0] mem_a_o,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o,
  output logic                   inst_valid_o
);

  fetch_state_e             state_q, state_d;
  logic [InstAddrBus-1:0]   fetch_pc_q, fetch_pc_d;
  logic [1:0]               k_q, k_d;
  logic                     pending_q, pending_d;
  logic [1:0]               slot_q, slot_d;
  logic [3:0][7:0]          asm_q, asm_d;
  logic [InstAddrBus-1:0]   pc_q, pc_d;
  logic [InstBus-1:0]       inst_q, inst_d;
  logic                     valid_q, valid_d;
  logic                     issue;

  assign mem_req_o    = rdy && !rst && (state_q == S_FETCH);
  assign mem_a_o      = mem_req_o ? fetch_pc_q + {30'b0, k_q} : '0;
  assign issue        = mem_req_o && mem_grant_i;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    k_d        = k_q;
    pending_d  = pending_q;
    slot_d     = slot_q;
    asm_d      = asm_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    valid_d    = valid_q;

    if (!rdy) begin
      // Frozen, except that any byte in flight is dropped and a partial fetch
      // is rewound so it restarts from byte 0 at the same PC.
      pending_d = False_v;
      if (state_q != S_HOLD) begin
        state_d = S_FETCH;
        k_d     = '0;
      end
    end else begin
      pending_d = issue;
      if (issue) slot_d = k_q;
      if (pending_q) asm_d[slot_q] = mem_din_i;

      unique case (state_q)
        S_FETCH: begin
          if (issue) begin
            k_d = 2'(k_q + 2'd1);
            if (k_q == 2'd3) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          inst_d  = asm_d;
          pc_d    = fetch_pc_q;
          valid_d = True_v;
          state_d = S_HOLD;
        end
        S_HOLD: begin
          if (valid_q && id_ready_i) begin
            valid_d    = False_v;
            fetch_pc_d = fetch_pc_q + 32'd4;
            k_d        = '0;
            state_d    = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase

      if (branch_enable_i) begin
        fetch_pc_d = branch_addr_i;
        k_d        = '0;
        pending_d  = False_v;
        valid_d    = False_v;
        state_d    = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      k_q        <= '0;
      pending_q  <= False_v;
      slot_q     <= '0;
      asm_q      <= '0;
      pc_q       <= '0;
      inst_q     <= '0;
      valid_q    <= False_v;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      k_q        <= k_d;
      pending_q  <= pending_d;
      slot_q     <= slot_d;
      asm_q      <= asm_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
    end
  end

endmodule
